// File: rtl/multi_downcounter.sv
// NUM_CH independent programmable down-counters, each giving a one-cycle zero pulse on expiry (periodic or one-shot).
// Optional macro DOWNCOUNTER_PRESCALE_EN adds a shared free-running prescaler that gates every channel's decrement.
module multi_downcounter #(
    parameter int NUM_CH         = 4,
    parameter int WIDTH          = 9,
    parameter int DEFAULT_PERIOD = 392,
    parameter int PRESCALE       = 1,
    localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [WIDTH-1:0]  cfg_period,
    input  logic              cfg_oneshot,
    output logic              cfg_err,
    input  logic [NUM_CH-1:0] start,
    input  logic [NUM_CH-1:0] stop,
    output logic [NUM_CH-1:0] zero,
    output logic [NUM_CH-1:0] busy
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic [WIDTH-1:0] DEF_P    = WIDTH'(DEFAULT_PERIOD);
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [CH_W:0]    NUM_CH_L = (CH_W + 1)'(NUM_CH);

    state_e           state_q  [NUM_CH];
    state_e           state_d  [NUM_CH];
    logic [WIDTH-1:0] period_q [NUM_CH];
    logic [WIDTH-1:0] period_d [NUM_CH];
    logic [WIDTH-1:0] count_q  [NUM_CH];
    logic [WIDTH-1:0] count_d  [NUM_CH];
    logic [WIDTH-1:0] load_val [NUM_CH];
    logic [NUM_CH-1:0] oneshot_q, oneshot_d;
    logic [NUM_CH-1:0] zero_q, zero_d;
    logic [NUM_CH-1:0] wr_hit;
    logic              cfg_ok;
    logic              cfg_err_q, cfg_err_d;
    logic              tick;

`ifdef DOWNCOUNTER_PRESCALE_EN
    localparam int            PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

    logic [PW-1:0] presc_q, presc_d;

    assign tick    = (presc_q == '0);
    assign presc_d = tick ? PRE_MAX : (presc_q - PW'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q <= PRE_MAX;
        end else begin
            presc_q <= presc_d;
        end
    end
`else
    // Every cycle is a tick; PRESCALE only matters for the prescaled build.
    assign tick = (PRESCALE >= 1);
`endif

    assign cfg_ok    = (cfg_period != '0) && ({1'b0, cfg_ch} < NUM_CH_L);
    assign cfg_err_d = cfg_we && !cfg_ok;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            wr_hit[i]    = cfg_we && cfg_ok && (cfg_ch == CH_W'(i));
            period_d[i]  = period_q[i];
            oneshot_d[i] = oneshot_q[i];
            state_d[i]   = state_q[i];
            count_d[i]   = count_q[i];
            zero_d[i]    = 1'b0;
            // A write in the same cycle as start/stop is visible to that load.
            load_val[i]  = (wr_hit[i] ? cfg_period : period_q[i]) - ONE;

            if (wr_hit[i]) begin
                period_d[i]  = cfg_period;
                oneshot_d[i] = cfg_oneshot;
            end

            if (stop[i]) begin
                state_d[i] = IDLE;
                count_d[i] = load_val[i];
            end else if (start[i]) begin
                state_d[i] = RUN;
                count_d[i] = load_val[i];
            end else if (state_q[i] == RUN && tick) begin
                if (count_q[i] == '0) begin
                    zero_d[i]  = 1'b1;
                    count_d[i] = period_q[i] - ONE;
                    if (oneshot_q[i]) begin
                        state_d[i] = IDLE;
                    end
                end else begin
                    count_d[i] = count_q[i] - ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cfg_err_q <= 1'b0;
            oneshot_q <= '0;
            zero_q    <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i]  <= IDLE;
                period_q[i] <= DEF_P;
                count_q[i]  <= DEF_P - ONE;
            end
        end else begin
            cfg_err_q <= cfg_err_d;
            oneshot_q <= oneshot_d;
            zero_q    <= zero_d;
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i]  <= state_d[i];
                period_q[i] <= period_d[i];
                count_q[i]  <= count_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            busy[i] = (state_q[i] == RUN);
        end
    end

    assign zero    = zero_q;
    assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_multi_downcounter.sv
// Directed bench for multi_downcounter: per-cycle vector table plus hand sequences for long periods,
// mid-count reprogramming, rejected writes, stop/start priority and asynchronous reset.
module tb_multi_downcounter;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    // main instance: 4 channels, 9-bit, default period 392
    logic       cfg_we, cfg_oneshot, cfg_err;
    logic [1:0] cfg_ch;
    logic [8:0] cfg_period;
    logic [3:0] start, stop, zero, busy;

    multi_downcounter #(.NUM_CH(4), .WIDTH(9), .DEFAULT_PERIOD(392), .PRESCALE(1)) dut (
        .clk(clk), .reset_n(reset_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_period(cfg_period), .cfg_oneshot(cfg_oneshot), .cfg_err(cfg_err),
        .start(start), .stop(stop), .zero(zero), .busy(busy)
    );

    // 3-channel instance so that an out-of-range channel index is representable
    logic       s_cfg_we, s_cfg_oneshot, s_cfg_err;
    logic [1:0] s_cfg_ch;
    logic [3:0] s_cfg_period;
    logic [2:0] s_start, s_stop, s_zero, s_busy;

    multi_downcounter #(.NUM_CH(3), .WIDTH(4), .DEFAULT_PERIOD(5), .PRESCALE(1)) s_dut (
        .clk(clk), .reset_n(reset_n), .cfg_we(s_cfg_we), .cfg_ch(s_cfg_ch),
        .cfg_period(s_cfg_period), .cfg_oneshot(s_cfg_oneshot), .cfg_err(s_cfg_err),
        .start(s_start), .stop(s_stop), .zero(s_zero), .busy(s_busy)
    );

`ifdef DOWNCOUNTER_PRESCALE_EN
    logic       p_cfg_we, p_cfg_oneshot, p_cfg_err;
    logic [0:0] p_cfg_ch;
    logic [3:0] p_cfg_period;
    logic [0:0] p_start, p_stop, p_zero, p_busy;

    multi_downcounter #(.NUM_CH(1), .WIDTH(4), .DEFAULT_PERIOD(2), .PRESCALE(3)) p_dut (
        .clk(clk), .reset_n(reset_n), .cfg_we(p_cfg_we), .cfg_ch(p_cfg_ch),
        .cfg_period(p_cfg_period), .cfg_oneshot(p_cfg_oneshot), .cfg_err(p_cfg_err),
        .start(p_start), .stop(p_stop), .zero(p_zero), .busy(p_busy)
    );
`endif

    typedef struct {
        logic       we;
        logic [1:0] ch;
        logic [8:0] per;
        logic       os;
        logic [3:0] st;
        logic [3:0] sp;
        logic [3:0] ezero;
        logic [3:0] ebusy;
        logic       eerr;
    } vec_t;

    vec_t vecs[22];
    int   passed = 0;
    int   total  = 0;

    function automatic vec_t mk(logic we, logic [1:0] ch, logic [8:0] per, logic os,
                                logic [3:0] st, logic [3:0] sp,
                                logic [3:0] ez, logic [3:0] eb, logic ee);
        vec_t v;
        v.we = we; v.ch = ch; v.per = per; v.os = os; v.st = st; v.sp = sp;
        v.ezero = ez; v.ebusy = eb; v.eerr = ee;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cfg_we = 1'b0; cfg_ch = '0; cfg_period = '0; cfg_oneshot = 1'b0;
        start = '0; stop = '0;
        s_cfg_we = 1'b0; s_cfg_ch = '0; s_cfg_period = '0; s_cfg_oneshot = 1'b0;
        s_start = '0; s_stop = '0;
`ifdef DOWNCOUNTER_PRESCALE_EN
        p_cfg_we = 1'b0; p_cfg_ch = '0; p_cfg_period = '0; p_cfg_oneshot = 1'b0;
        p_start = '0; p_stop = '0;
`endif
    endtask

    task automatic write_cfg(input logic [1:0] ch, input logic [8:0] per, input logic os);
        cfg_we = 1'b1; cfg_ch = ch; cfg_period = per; cfg_oneshot = os;
    endtask

    int pulses[$];
    int other_bad;
    int cnt;

    initial begin
        idle_inputs();

        // table: ch1 one-shot P=3, rejected write, bypass P=1, stop priority, ch3 P=2 alongside ch2
        vecs[0]  = mk(1, 2'd1, 9'd3, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0);
        vecs[1]  = mk(0, 2'd0, 9'd0, 0, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 0);
        vecs[2]  = mk(0, 2'd0, 9'd0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 0);
        vecs[3]  = mk(0, 2'd0, 9'd0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 0);
        vecs[4]  = mk(0, 2'd0, 9'd0, 0, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 0);
        vecs[5]  = mk(0, 2'd0, 9'd0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0);
        vecs[6]  = mk(1, 2'd2, 9'd0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1);
        vecs[7]  = mk(0, 2'd0, 9'd0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0);
        vecs[8]  = mk(1, 2'd2, 9'd1, 0, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 0);
        vecs[9]  = mk(0, 2'd0, 9'd0, 0, 4'b0000, 4'b0000, 4'b0100, 4'b0100, 0);
        vecs[10] = mk(0, 2'd0, 9'd0, 0, 4'b0000, 4'b0000, 4'b0100, 4'b0100, 0);
        vecs[11] = mk(0, 2'd0, 9'd0, 0, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 0);
        vecs[12] = mk(0, 2'd0, 9'd0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0);
        vecs[13] = mk(0, 2'd0, 9'd0, 0, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 0);
        vecs[14] = mk(1, 2'd3, 9'd2, 0, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 0);
        vecs[15] = mk(0, 2'd0, 9'd0, 0, 4'b1000, 4'b0000, 4'b0100, 4'b1100, 0);
        vecs[16] = mk(0, 2'd0, 9'd0, 0, 4'b0000, 4'b0000, 4'b0100, 4'b1100, 0);
        vecs[17] = mk(0, 2'd0, 9'd0, 0, 4'b0000, 4'b0000, 4'b1100, 4'b1100, 0);
        vecs[18] = mk(0, 2'd0, 9'd0, 0, 4'b1000, 4'b0000, 4'b0100, 4'b1100, 0);
        vecs[19] = mk(0, 2'd0, 9'd0, 0, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 0);
        vecs[20] = mk(0, 2'd0, 9'd0, 0, 4'b0000, 4'b0000, 4'b1000, 4'b1000, 0);
        vecs[21] = mk(0, 2'd0, 9'd0, 0, 4'b0000, 4'b1000, 4'b0000, 4'b0000, 0);

        // reset state
        #12;
        check("reset zero", 32'(zero), 0);
        check("reset busy", 32'(busy), 0);
        check("reset cfg_err", 32'(cfg_err), 0);
        check("reset s_busy", 32'(s_busy), 0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 22; i++) begin
            cfg_we = vecs[i].we; cfg_ch = vecs[i].ch; cfg_period = vecs[i].per;
            cfg_oneshot = vecs[i].os; start = vecs[i].st; stop = vecs[i].sp;
            step();
            check($sformatf("vec%0d zero", i), 32'(zero), 32'(vecs[i].ezero));
            check($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].ebusy));
            check($sformatf("vec%0d cfg_err", i), 32'(cfg_err), 32'(vecs[i].eerr));
        end
        idle_inputs();

        // ch0 at the reset period: pulses 392, 784, 1176 edges after start
        start = 4'b0001;
        step();
        start = '0;
        check("seqA busy", 32'(busy), 32'h1);
        pulses.delete();
        other_bad = 0;
        for (int k = 1; k <= 1180; k++) begin
            step();
            if (zero[0]) pulses.push_back(k);
            if (zero[3:1] != 3'b000) other_bad++;
        end
        check("seqA pulse count", 32'(pulses.size()), 3);
        for (int i = 0; i < 3; i++)
            check($sformatf("seqA pulse%0d", i), (i < pulses.size()) ? 32'(pulses[i]) : 32'hffff_ffff,
                  32'(392 * (i + 1)));
        check("seqA other channels", 32'(other_bad), 0);
        stop = 4'b0001;
        step();
        stop = '0;
        check("seqA stop busy", 32'(busy), 0);

        // ch2 P=8, reprogrammed to 3 mid-count: pulses at 8, 11, 14
        write_cfg(2'd2, 9'd8, 1'b0);
        step();
        idle_inputs();
        start = 4'b0100;
        step();
        start = '0;
        pulses.delete();
        for (int k = 1; k <= 16; k++) begin
            if (k == 4) write_cfg(2'd2, 9'd3, 1'b0);
            else cfg_we = 1'b0;
            step();
            if (zero[2]) pulses.push_back(k);
        end
        idle_inputs();
        check("seqB pulse count", 32'(pulses.size()), 3);
        check("seqB pulse0", (pulses.size() > 0) ? 32'(pulses[0]) : 32'hffff_ffff, 8);
        check("seqB pulse1", (pulses.size() > 1) ? 32'(pulses[1]) : 32'hffff_ffff, 11);
        check("seqB pulse2", (pulses.size() > 2) ? 32'(pulses[2]) : 32'hffff_ffff, 14);
        stop = 4'b0100;
        step();
        stop = '0;

        // rejected zero-period write leaves ch1 as one-shot P=3
        write_cfg(2'd1, 9'd0, 1'b0);
        step();
        idle_inputs();
        check("err period0 pulse", 32'(cfg_err), 1);
        step();
        check("err period0 clears", 32'(cfg_err), 0);
        start = 4'b0010;
        step();
        start = '0;
        check("oneshot busy", 32'(busy), 32'h2);
        step();
        check("oneshot edge1", 32'(zero), 0);
        step();
        check("oneshot edge2", 32'(zero), 0);
        step();
        check("oneshot expiry zero", 32'(zero), 32'h2);
        check("oneshot expiry busy", 32'(busy), 0);
        cnt = 0;
        for (int k = 0; k < 100; k++) begin
            step();
            if (zero[1]) cnt++;
        end
        check("oneshot no repeat", 32'(cnt), 0);

        // out-of-range channel on the 3-channel instance
        s_cfg_we = 1'b1; s_cfg_ch = 2'd3; s_cfg_period = 4'd1; s_cfg_oneshot = 1'b1;
        step();
        s_cfg_we = 1'b0;
        check("err bad channel", 32'(s_cfg_err), 1);
        step();
        check("err bad channel clears", 32'(s_cfg_err), 0);
        s_cfg_we = 1'b1; s_cfg_ch = 2'd2; s_cfg_period = 4'd2; s_cfg_oneshot = 1'b0;
        step();
        s_cfg_we = 1'b0;
        check("good write no err", 32'(s_cfg_err), 0);
        s_start = 3'b100;
        step();
        s_start = '0;
        step();
        check("small ch2 edge1", 32'(s_zero), 0);
        step();
        check("small ch2 expiry", 32'(s_zero), 32'h4);
        s_stop = 3'b100;
        step();
        s_stop = '0;

        // ch0 P=4: start+stop together at count 2, then async reset while zero is high
        write_cfg(2'd0, 9'd4, 1'b0);
        step();
        idle_inputs();
        start = 4'b0001;
        step();
        start = '0;
        step();
        start = 4'b0001; stop = 4'b0001;
        step();
        start = '0; stop = '0;
        check("stop wins busy", 32'(busy), 0);
        check("stop wins zero", 32'(zero), 0);
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (zero != 4'b0000) cnt++;
        end
        check("stopped stays quiet", 32'(cnt), 0);
        start = 4'b0001;
        step();
        start = '0;
        for (int k = 0; k < 4; k++) step();
        check("seqC pulse before reset", 32'(zero), 32'h1);
        #2 reset_n = 1'b0;
        #1;
        check("async reset zero", 32'(zero), 0);
        check("async reset busy", 32'(busy), 0);
        check("async reset cfg_err", 32'(cfg_err), 0);
        @(negedge clk);
        reset_n = 1'b1;
        step();
        check("post reset busy", 32'(busy), 0);

`ifdef DOWNCOUNTER_PRESCALE_EN
        // PRESCALE=3, P=2: one-clk pulses every 6 clks
        p_start = 1'b1;
        step();
        p_start = 1'b0;
        pulses.delete();
        cnt = 0;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (p_zero[0]) begin
                if (pulses.size() > 0 && pulses[pulses.size() - 1] == k - 1) cnt++;
                pulses.push_back(k);
            end
        end
        check("presc pulse width", 32'(cnt), 0);
        check("presc enough pulses", 32'(pulses.size() >= 3), 1);
        for (int i = 1; i < 3; i++)
            check($sformatf("presc spacing%0d", i),
                  (i < pulses.size()) ? 32'(pulses[i] - pulses[i - 1]) : 32'hffff_ffff, 6);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
